uart_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single UART transmit AXI-Stream byte port between several requesters, e.g. the Wishbone response path and a debug/log streamer. It sits between the requester streams and the UART transmitter's s_axis input. It locks the grant for a whole packet (tvalid..tlast), so response frames are never interleaved on the serial line. A stall watchdog reclaims the port from a source that stops mid-packet.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and default parameters for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_SRC    = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or above ptr, wrapping
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] index,
    output logic             any_req
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N);

    always_comb begin
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] idx;
        grant   = '0;
        index   = '0;
        any_req = 1'b0;
        pos     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (pos >= N_EXT) begin
                pos = pos - N_EXT;
            end
            idx = pos[PTR_W-1:0];
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                index      = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter in front of the UART TX byte stream
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [NUM_SRC-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state, state_next;
    logic [NUM_SRC-1:0] grant_q, grant_next;
    logic [PTR_W-1:0] grant_idx, grant_idx_next;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_next, ptr_after;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_next;
    logic             timeout_next;

    logic [NUM_SRC-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic                  locked, sel_valid, sel_last, handshake;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_pick #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .index   (pick_idx),
        .any_req (pick_any)
    );

    assign locked    = (state == LOCKED);
    assign handshake = locked && sel_valid && m_axis_tready;
    assign ptr_after = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Zero-latency mux from the owning source; constant slices keep the select simple.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                sel_data  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
            end
        end
    end

    assign m_axis_tdata  = locked ? sel_data : '0;
    assign m_axis_tvalid = locked && sel_valid;
    assign m_axis_tlast  = locked && sel_last;
    assign s_axis_tready = (locked && m_axis_tready) ? grant_q : '0;
    assign o_grant       = grant_q;
    assign o_busy        = locked;

    always_comb begin
        state_next     = state;
        grant_next     = grant_q;
        grant_idx_next = grant_idx;
        rr_ptr_next    = rr_ptr;
        stall_cnt_next = stall_cnt;
        timeout_next   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next     = LOCKED;
                    grant_next     = pick_grant;
                    grant_idx_next = pick_idx;
                    stall_cnt_next = '0;
                end
            end
            LOCKED: begin
                if (handshake) begin
                    stall_cnt_next = '0;
                    if (sel_last) begin
                        state_next  = IDLE;
                        grant_next  = '0;
                        rr_ptr_next = ptr_after;
                    end
                end else if (!sel_valid) begin
                    // Only a silent source counts as stalled; sink backpressure never does.
                    if (WD_EN && stall_cnt == STALL_LIMIT) begin
                        timeout_next = 1'b1;
                        state_next   = IDLE;
                        grant_next   = '0;
                        rr_ptr_next  = ptr_after;
                    end else if (stall_cnt != '1) begin
                        stall_cnt_next = stall_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            grant_q   <= grant_next;
            grant_idx <= grant_idx_next;
            rr_ptr    <= rr_ptr_next;
            stall_cnt <= stall_cnt_next;
            o_timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench for uart_tx_arbiter against a packet-level reference model
module tb_uart_tx_arbiter;

    localparam int NSRC = 2;
    localparam int DW   = 8;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NSRC*DW-1:0]   s_tdata;
    logic [NSRC-1:0]      s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid, m_tlast, m_tready;
    logic [NSRC-1:0]      grant;
    logic                 busy, tout;

    uart_tx_arbiter #(
        .NUM_SRC    (NSRC),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_timeout     (tout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: packet owner, rotation pointer, silent-cycle run length
    int owner   = -1;
    int ptr     = 0;
    int run     = 0;
    bit to_flag = 1'b0;
    int cyc     = 0;

    logic [8:0] srcq [NSRC][$];
    int gap_left [NSRC];
    int ready_mode  = 0;
    int refill_mode = 0;
    bit gap_en      = 1'b0;

    int to_seen_cyc   = -1;
    int src0_grant_cyc = -1;
    int src1_last_hs  = -1;
    int src0_hs       = 0;
    int to_count      = 0;
    bit busy_prev     = 1'b0;
    bit fair_en       = 1'b0;
    logic [NSRC-1:0] last_grant = '0;
    logic [8:0] out_log [$];
    int grant_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            srcq[s].push_back({(i == len - 1), 8'($urandom)});
        end
    endtask

    task automatic step();
        logic [NSRC-1:0] exp_grant, exp_ready;
        bit exp_busy, exp_valid, last_beat;
        int k;
        @(negedge clk);
        for (int s = 0; s < NSRC; s++) begin
            if (refill_mode == 1 && srcq[s].size() < 8) push_pkt(s, 4);
            else if (refill_mode == 2 && srcq[s].size() < 6) push_pkt(s, int'($urandom_range(1, 5)));
            if (gap_en) begin
                if (gap_left[s] > 0) gap_left[s]--;
                else if ($urandom_range(0, 99) < 8)
                    gap_left[s] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 24))
                                                               : int'($urandom_range(1, 4));
            end
            s_tvalid[s]          = (srcq[s].size() > 0) && (gap_left[s] == 0);
            s_tdata[s*DW +: DW]  = (srcq[s].size() > 0) ? srcq[s][0][7:0] : DW'($urandom);
            s_tlast[s]           = (srcq[s].size() > 0) ? srcq[s][0][8] : 1'b0;
        end
        case (ready_mode)
            1:       m_tready = (cyc % 10 == 0);
            2:       m_tready = ($urandom_range(0, 1) == 1);
            default: m_tready = 1'b1;
        endcase
        #1;
        exp_busy  = (owner >= 0);
        exp_grant = exp_busy ? (NSRC'(1) << owner) : '0;
        exp_valid = exp_busy && s_tvalid[owner];
        exp_ready = (exp_busy && m_tready) ? exp_grant : '0;
        check_eq("busy", busy, exp_busy);
        check_eq("grant", grant, exp_grant);
        check_eq("s_tready", s_tready, exp_ready);
        check_eq("m_tvalid", m_tvalid, exp_valid);
        check_eq("timeout", tout, to_flag);
        if (exp_valid) begin
            check_eq("m_tdata", m_tdata, srcq[owner][0][7:0]);
            check_eq("m_tlast", m_tlast, srcq[owner][0][8]);
        end
        if (tout) begin
            to_count++;
            if (to_seen_cyc < 0) to_seen_cyc = cyc;
        end
        if (s_tvalid[1] && s_tready[1]) src1_last_hs = cyc;
        if (s_tvalid[0] && s_tready[0]) src0_hs++;
        if (grant == 2'b01 && to_seen_cyc >= 0 && src0_grant_cyc < 0 && cyc > to_seen_cyc)
            src0_grant_cyc = cyc;
        if (grant == 2'b01) grant_log.push_back(cyc);
        if (m_tvalid && m_tready) out_log.push_back({m_tlast, m_tdata});
        if (fair_en && busy && !busy_prev) begin
            if (last_grant != '0) check_eq("fair_order", grant, last_grant ^ 2'b11);
            last_grant = grant;
        end
        busy_prev = busy;
        if (!rst_n) begin
            owner = -1; ptr = 0; run = 0; to_flag = 1'b0;
        end else if (owner < 0) begin
            to_flag = 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                k = (ptr + i) % NSRC;
                if (owner < 0 && s_tvalid[k]) begin
                    owner = k;
                    run   = 0;
                end
            end
        end else begin
            to_flag = 1'b0;
            if (s_tvalid[owner] && m_tready) begin
                last_beat = srcq[owner][0][8];
                void'(srcq[owner].pop_front());
                run = 0;
                if (last_beat) begin
                    ptr   = (owner + 1) % NSRC;
                    owner = -1;
                end
            end else if (!s_tvalid[owner]) begin
                run++;
                if (run == TO) begin
                    to_flag = 1'b1;
                    ptr     = (owner + 1) % NSRC;
                    owner   = -1;
                end
            end
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit done;
        refill_mode = 0;
        gap_en      = 1'b0;
        for (int s = 0; s < NSRC; s++) gap_left[s] = 0;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (owner < 0) && (srcq[0].size() == 0) && (srcq[1].size() == 0);
        end
        check_eq("drain_done", done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int start;
        rst_n    = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        for (int s = 0; s < NSRC; s++) gap_left[s] = 0;
        #23;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_m_tvalid", m_tvalid, 1'b0);
        check_eq("rst_m_tdata", m_tdata, 8'h00);
        check_eq("rst_m_tlast", m_tlast, 1'b0);
        check_eq("rst_s_tready", s_tready, 2'b00);
        check_eq("rst_timeout", tout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) step();

        // single packet from source 0
        out_log.delete();
        grant_log.delete();
        srcq[0].push_back(9'h055);
        srcq[0].push_back(9'h0AA);
        srcq[0].push_back(9'h10D);
        start = cyc;
        repeat (8) step();
        check_eq("single_nbytes", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_eq("single_b0", out_log[0], 9'h055);
            check_eq("single_b1", out_log[1], 9'h0AA);
            check_eq("single_b2", out_log[2], 9'h10D);
        end
        check_eq("single_grant_len", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check_eq("single_grant_first", grant_log[0] - start, 1);
            check_eq("single_grant_last", grant_log[2] - start, 3);
        end
        check_eq("single_idle", busy, 1'b0);

        // watchdog: source 1 owns the port then goes silent, source 0 waiting
        srcq[1].push_back(9'h031);
        srcq[1].push_back(9'h032);
        push_pkt(0, 3);
        to_seen_cyc    = -1;
        src0_grant_cyc = -1;
        src1_last_hs   = -1;
        for (int i = 0; i < 80 && src0_grant_cyc < 0; i++) step();
        check_eq("wd_seen", (to_seen_cyc >= 0), 1'b1);
        check_eq("wd_delay", to_seen_cyc - src1_last_hs, TO + 1);
        check_eq("wd_regrant", src0_grant_cyc - to_seen_cyc, 1);
        drain(50);

        // fairness with both sources saturated
        refill_mode = 1;
        fair_en     = 1'b1;
        last_grant  = '0;
        repeat (400) step();
        fair_en = 1'b0;
        drain(100);

        // reset in the middle of a 5-byte packet
        push_pkt(0, 1);
        drain(20);
        push_pkt(0, 5);
        src0_hs = 0;
        for (int i = 0; i < 20 && src0_hs < 2; i++) step();
        check_eq("mid_two_bytes", src0_hs, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_grant", grant, 2'b00);
        check_eq("mid_rst_m_tvalid", m_tvalid, 1'b0);
        check_eq("mid_rst_m_tlast", m_tlast, 1'b0);
        check_eq("mid_rst_s_tready", s_tready, 2'b00);
        owner = -1; ptr = 0; run = 0; to_flag = 1'b0;
        for (int s = 0; s < NSRC; s++) srcq[s].delete();
        repeat (3) step();
        rst_n = 1'b1;
        push_pkt(0, 2);
        push_pkt(1, 2);
        step();
        step();
        check_eq("rst_restart_src0", grant, 2'b01);
        drain(30);

        // UART pacing: sink ready one cycle in ten
        ready_mode  = 1;
        refill_mode = 2;
        to_count    = 0;
        repeat (2000) step();
        check_eq("bp_no_timeout", to_count, 0);
        ready_mode = 0;
        drain(100);

        // random gaps, random backpressure, occasional stalls long enough to time out
        ready_mode  = 2;
        refill_mode = 2;
        gap_en      = 1'b1;
        repeat (3000) step();
        ready_mode = 0;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
